pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard controller for the 5-stage core; it sequences the execute stage.
//  Detects load-use hazards, branch-redirect flushes and memory wait-states.
//  Drives per-stage stall/flush lines, including stall_in of the execute stage.
//  Generates rs1/rs2 forwarding selects for the operand muxes ahead of the ALU.
// PARAMETERS
//  FLUSH_CYCLES  2   younger stages squashed after a taken branch (>=1)
//  CNT_W         16  width of bubble_count perf counter
// PORTS
//  req           in   1      clock; all state updates on posedge req
//  rst_n         in   1      reset; synchronous, active-low
//  id_valid      in   1      decode stage holds a valid instruction
//  id_rs1        in   5      decode rs1 index
//  id_rs2        in   5      decode rs2 index
//  ex_valid      in   1      execute stage holds a valid instruction
//  ex_is_load    in   1      execute instruction is a load
//  ex_rd_write   in   1      execute instruction writes rd
//  ex_rd         in   5      execute destination index
//  mem_rd_write  in   1      memory-stage instruction writes rd
//  mem_rd        in   5      memory-stage destination index
//  wb_rd_write   in   1      writeback instruction writes rd
//  wb_rd         in   5      writeback destination index
//  ex_branch_tkn in   1      execute resolved a taken branch/jump this cycle
//  mem_busy      in   1      data memory not ready; whole pipe must hold
//  stall_if      out  1      hold PC/fetch register
//  stall_id      out  1      hold decode register
//  stall_ex      out  1      hold execute stage (to execute stall_in)
//  flush_id      out  1      squash decode register to bubble
//  flush_ex      out  1      insert bubble into execute on next edge
//  fwd_rs1_sel   out  2      00 regfile, 01 from MEM result, 10 from WB result
//  fwd_rs2_sel   out  2      same encoding for rs2
//  bubble_count  out  CNT_W  cycles with stall_if or flush_id high; saturating
//  state_out     out  2      FSM state: RUN=0 LOAD_STALL=1 FLUSH=2 MEM_WAIT=3
// BEHAVIOUR
//  - Stall/flush/fwd outputs are combinational from state+inputs (same-cycle
//    effect); all are forced 0 while rst_n=0. Registered: state, flush counter,
//    pend_flush, bubble_count.
//  - Reset (rst_n=0 at edge): state=RUN, cnt=0, pend_flush=0, bubble_count=0;
//    aborts any flush or stall in progress.
//  - hazard = id_valid & ex_valid & ex_is_load & ex_rd_write & ex_rd!=0 &
//    (ex_rd==id_rs1 | ex_rd==id_rs2).
//  - Priority per cycle: mem_busy > branch (incl. pending) > load-use.
//  - Any state, mem_busy=1: stall_if=stall_id=stall_ex=1, flushes=0, next
//    MEM_WAIT; ex_branch_tkn=1 here sets pend_flush.
//  - MEM_WAIT, mem_busy=0: pend_flush=1 -> treated as a branch in RUN (below),
//    pend_flush cleared; else evaluate as RUN.
//  - RUN, ex_branch_tkn=1: flush_id=flush_ex=1, no stall; cnt<=FLUSH_CYCLES-1;
//    next FLUSH if FLUSH_CYCLES>1 else RUN. Overrides a coincident hazard.
//  - RUN, hazard: stall_if=stall_id=1, flush_ex=1 (one bubble); next LOAD_STALL.
//  - LOAD_STALL: no stall regardless of hazard (the load has advanced);
//    forwarding from MEM covers it; ex_branch_tkn is ignored (EX holds bubble).
//    Next RUN.
//  - FLUSH: flush_id=1 each cycle, ex_branch_tkn ignored; cnt decrements;
//    cnt==1 at edge -> RUN.
//  - Forwarding (all states): sel=01 if mem_rd_write & mem_rd!=0 & mem_rd==rs;
//    else 10 if wb_rd_write & wb_rd!=0 & wb_rd==rs; else 00. MEM wins ties.
//  - bubble_count += 1 on each edge where stall_if|flush_id; holds at all-ones.
// TESTING
//  1 Load x5 in EX, decode uses rs1=5 -> 1 cycle stall_if/id=1, flush_ex=1,
//    state 0->1->0; next cycle fwd_rs1_sel=01; bubble_count=1.
//  2 Taken branch, FLUSH_CYCLES=2 -> flush_id=1 for 2 cycles, flush_ex=1 for
//    cycle 1 only, back to RUN; bubble_count=2.
//  3 mem_busy high 3 cycles with ex_branch_tkn=1 in 1st -> all stalls 3 cycles,
//    state=3; on release branch flush applied once, pend_flush cleared.
//  4 mem_rd=wb_rd=7, both writing, id_rs2=7 -> fwd_rs2_sel=01; rd=0 -> 00.
//  5 rst_n=0 mid-FLUSH -> next cycle state=0, all outputs 0, bubble_count=0.
//  6 CNT_W=4, 20 stall cycles -> bubble_count stays at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the hazard information from the pipeline stages and the
//   stall/flush/forwarding controls that go back to them.
//   master : pipeline side. It drives the stage status and receives the controls.
//   slave  : hazard controller side. It receives the stage status and drives the controls.
//   Stage status : id_valid, id_rs1, id_rs2, ex_valid, ex_is_load, ex_rd_write, ex_rd,
//                  mem_rd_write, mem_rd, wb_rd_write, wb_rd, ex_branch_tkn, mem_busy
//   Controls     : stall_if, stall_id, stall_ex, flush_id, flush_ex,
//                  fwd_rs1_sel, fwd_rs2_sel, bubble_count, state_out
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_valid;
    logic             ex_is_load;
    logic             ex_rd_write;
    logic [4:0]       ex_rd;
    logic             mem_rd_write;
    logic [4:0]       mem_rd;
    logic             wb_rd_write;
    logic [4:0]       wb_rd;
    logic             ex_branch_tkn;
    logic             mem_busy;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             flush_id;
    logic             flush_ex;
    logic [1:0]       fwd_rs1_sel;
    logic [1:0]       fwd_rs2_sel;
    logic [CNT_W-1:0] bubble_count;
    logic [1:0]       state_out;

    modport master (
        output id_valid, id_rs1, id_rs2, ex_valid, ex_is_load, ex_rd_write, ex_rd,
               mem_rd_write, mem_rd, wb_rd_write, wb_rd, ex_branch_tkn, mem_busy,
        input  stall_if, stall_id, stall_ex, flush_id, flush_ex,
               fwd_rs1_sel, fwd_rs2_sel, bubble_count, state_out
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, ex_valid, ex_is_load, ex_rd_write, ex_rd,
               mem_rd_write, mem_rd, wb_rd_write, wb_rd, ex_branch_tkn, mem_busy,
        output stall_if, stall_id, stall_ex, flush_id, flush_ex,
               fwd_rs1_sel, fwd_rs2_sel, bubble_count, state_out
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard controller for the 5-stage core. It detects load-use hazards,
//   taken-branch flushes and data-memory wait states. It drives the per-stage
//   stall and flush lines and the rs1/rs2 forwarding selects.
//   req   : clock; all state updates happen on posedge req
//   rst_n : synchronous active-low reset
//   hz    : stage status in, stall/flush/forward controls out (slave modport)
//   The stall, flush and forward outputs are combinational from the state and
//   the inputs. They are forced low while rst_n is low.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                   req,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    state_t           state_r, state_d;
    logic [CW-1:0]    cnt_r, cnt_d;
    logic             pend_r, pend_d;
    logic [CNT_W-1:0] bubble_r;

    logic stall_if_c, stall_id_c, stall_ex_c, flush_id_c, flush_ex_c;
    logic run_eval, branch_eval, hazard;

    // MEM is the younger producer, so its result takes precedence over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic mem_wr, input logic [4:0] mem_rd,
                                           input logic wb_wr,  input logic [4:0] wb_rd);
        if (mem_wr && mem_rd != 5'd0 && mem_rd == rs)
            return 2'b01;
        else if (wb_wr && wb_rd != 5'd0 && wb_rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign hazard = hz.id_valid & hz.ex_valid & hz.ex_is_load & hz.ex_rd_write &
                    (hz.ex_rd != 5'd0) &
                    ((hz.ex_rd == hz.id_rs1) | (hz.ex_rd == hz.id_rs2));

    always_comb begin
        state_d     = state_r;
        cnt_d       = cnt_r;
        pend_d      = pend_r;
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        flush_id_c  = 1'b0;
        flush_ex_c  = 1'b0;
        run_eval    = 1'b0;
        branch_eval = 1'b0;

        if (hz.mem_busy) begin
            // Whole pipe holds. A branch resolved now is remembered and applied on release.
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            stall_ex_c = 1'b1;
            state_d    = MEM_WAIT;
            if (hz.ex_branch_tkn)
                pend_d = 1'b1;
        end else begin
            unique case (state_r)
                MEM_WAIT: begin
                    if (pend_r) begin
                        branch_eval = 1'b1;
                        pend_d      = 1'b0;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                RUN:        run_eval = 1'b1;
                // The load has moved to MEM and is covered by forwarding. EX holds a bubble.
                LOAD_STALL: state_d = RUN;
                FLUSH: begin
                    flush_id_c = 1'b1;
                    cnt_d      = cnt_r - CW'(1);
                    if (cnt_r == CW'(1))
                        state_d = RUN;
                end
                default:    state_d = RUN;
            endcase

            if (run_eval && hz.ex_branch_tkn)
                branch_eval = 1'b1;

            if (branch_eval) begin
                flush_id_c = 1'b1;
                flush_ex_c = 1'b1;
                cnt_d      = CW'(FLUSH_CYCLES - 1);
                state_d    = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end else if (run_eval && hazard) begin
                stall_if_c = 1'b1;
                stall_id_c = 1'b1;
                flush_ex_c = 1'b1;
                state_d    = LOAD_STALL;
            end else if (run_eval) begin
                state_d = RUN;
            end
        end
    end

    assign hz.stall_if     = rst_n & stall_if_c;
    assign hz.stall_id     = rst_n & stall_id_c;
    assign hz.stall_ex     = rst_n & stall_ex_c;
    assign hz.flush_id     = rst_n & flush_id_c;
    assign hz.flush_ex     = rst_n & flush_ex_c;
    assign hz.fwd_rs1_sel  = rst_n ? fwd_sel(hz.id_rs1, hz.mem_rd_write, hz.mem_rd,
                                             hz.wb_rd_write, hz.wb_rd) : 2'b00;
    assign hz.fwd_rs2_sel  = rst_n ? fwd_sel(hz.id_rs2, hz.mem_rd_write, hz.mem_rd,
                                             hz.wb_rd_write, hz.wb_rd) : 2'b00;
    assign hz.bubble_count = bubble_r;
    assign hz.state_out    = state_r;

    always_ff @(posedge req) begin
        if (!rst_n) begin
            state_r  <= RUN;
            cnt_r    <= '0;
            pend_r   <= 1'b0;
            bubble_r <= '0;
        end else begin
            state_r <= state_d;
            cnt_r   <= cnt_d;
            pend_r  <= pend_d;
            // Saturating count of lost issue slots.
            if ((stall_if_c | flush_id_c) && bubble_r != {CNT_W{1'b1}})
                bubble_r <= bubble_r + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    logic req = 1'b0;
    logic rst_n;
    logic       id_valid, ex_valid, ex_is_load, ex_rd_write, mem_rd_write, wb_rd_write;
    logic       ex_branch_tkn, mem_busy;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;

    int errors = 0;
    int checks = 0;

    always #5 req = ~req;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) hz ();
    pipeline_hazard_ctrl_if #(.CNT_W(16)) h1 ();
    pipeline_hazard_ctrl_if #(.CNT_W(4))  h4 ();

    // The same stimulus goes to every instance.
    `define TB_DRIVE(I) \
        assign I.id_valid = id_valid;  assign I.id_rs1 = id_rs1;  assign I.id_rs2 = id_rs2; \
        assign I.ex_valid = ex_valid;  assign I.ex_is_load = ex_is_load; \
        assign I.ex_rd_write = ex_rd_write; assign I.ex_rd = ex_rd; \
        assign I.mem_rd_write = mem_rd_write; assign I.mem_rd = mem_rd; \
        assign I.wb_rd_write = wb_rd_write; assign I.wb_rd = wb_rd; \
        assign I.ex_branch_tkn = ex_branch_tkn; assign I.mem_busy = mem_busy;
    `TB_DRIVE(hz)
    `TB_DRIVE(h1)
    `TB_DRIVE(h4)

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut  (.req(req), .rst_n(rst_n), .hz(hz));
    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut1 (.req(req), .rst_n(rst_n), .hz(h1));
    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4))  dut4 (.req(req), .rst_n(rst_n), .hz(h4));

    typedef struct {
        string      name;
        logic       idv;
        logic [4:0] rs1, rs2;
        logic       exv, ld, exw;
        logic [4:0] exrd;
        logic       mw;
        logic [4:0] mrd;
        logic       ww;
        logic [4:0] wrd;
        logic       br, busy;
        logic [8:0] exp;   // {stall_if,stall_id,stall_ex,flush_id,flush_ex,fwd1[1:0],fwd2[1:0]}
    } vec_t;

    vec_t vecs[15];

    function automatic logic [8:0] ctl(input logic unused);
        return {hz.stall_if, hz.stall_id, hz.stall_ex, hz.flush_id, hz.flush_ex,
                hz.fwd_rs1_sel, hz.fwd_rs2_sel};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge req);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd_write = 0; ex_rd = 0;
        mem_rd_write = 0; mem_rd = 0; wb_rd_write = 0; wb_rd = 0;
        ex_branch_tkn = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic load_hazard(input logic [4:0] rd, input logic [4:0] rs1);
        id_valid = 1; id_rs1 = rs1; ex_valid = 1; ex_is_load = 1; ex_rd_write = 1; ex_rd = rd;
    endtask

    initial begin
        //           name        idv rs1 rs2 exv ld exw exrd mw mrd ww wrd br busy exp
        vecs[0]  = '{"idle",       0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 9'b00000_00_00};
        vecs[1]  = '{"lu_rs1",     1, 5, 0, 1, 1, 1, 5,  0, 0, 0, 0, 0, 0, 9'b11001_00_00};
        vecs[2]  = '{"lu_rs2",     1, 3, 5, 1, 1, 1, 5,  0, 0, 0, 0, 0, 0, 9'b11001_00_00};
        vecs[3]  = '{"lu_rd0",     1, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 9'b00000_00_00};
        vecs[4]  = '{"not_load",   1, 5, 0, 1, 0, 1, 5,  0, 0, 0, 0, 0, 0, 9'b00000_00_00};
        vecs[5]  = '{"id_inval",   0, 5, 0, 1, 1, 1, 5,  0, 0, 0, 0, 0, 0, 9'b00000_00_00};
        vecs[6]  = '{"ex_nowr",    1, 5, 0, 1, 1, 0, 5,  0, 0, 0, 0, 0, 0, 9'b00000_00_00};
        vecs[7]  = '{"br_over_lu", 1, 5, 0, 1, 1, 1, 5,  0, 0, 0, 0, 1, 0, 9'b00011_00_00};
        vecs[8]  = '{"busy_top",   1, 5, 0, 1, 1, 1, 5,  0, 0, 0, 0, 1, 1, 9'b11100_00_00};
        vecs[9]  = '{"fwd_tie",    0, 0, 7, 0, 0, 0, 0,  1, 7, 1, 7, 0, 0, 9'b00000_00_01};
        vecs[10] = '{"fwd_rd0",    0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 9'b00000_00_00};
        vecs[11] = '{"fwd_wb",     0, 9, 0, 0, 0, 0, 0,  0, 9, 1, 9, 0, 0, 9'b00000_10_00};
        vecs[12] = '{"fwd_both",   0, 4, 6, 0, 0, 0, 0,  1, 4, 1, 6, 0, 0, 9'b00000_01_10};
        vecs[13] = '{"lu_and_fwd", 1, 5, 0, 1, 1, 1, 5,  1, 5, 0, 0, 0, 0, 9'b11001_01_00};
        vecs[14] = '{"fwd_wb_rs2", 0, 0, 7, 0, 0, 0, 0,  1, 3, 1, 7, 0, 0, 9'b00000_00_10};

        idle();
        rst_n = 0;
        load_hazard(5, 5);
        ex_branch_tkn = 1;
        #1;
        chk("in_reset_ctl", 32'(ctl(0)), 0);
        tick();
        rst_n = 1;
        idle();
        #1;
        chk("reset_state", 32'(hz.state_out), 0);
        chk("reset_bubble", 32'(hz.bubble_count), 0);

        for (int i = 0; i < 15; i++) begin
            do_reset();
            id_valid = vecs[i].idv; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            ex_valid = vecs[i].exv; ex_is_load = vecs[i].ld; ex_rd_write = vecs[i].exw;
            ex_rd = vecs[i].exrd; mem_rd_write = vecs[i].mw; mem_rd = vecs[i].mrd;
            wb_rd_write = vecs[i].ww; wb_rd = vecs[i].wrd;
            ex_branch_tkn = vecs[i].br; mem_busy = vecs[i].busy;
            #1;
            chk(vecs[i].name, 32'(ctl(0)), 32'(vecs[i].exp));
        end

        // Load-use: one stall cycle, then forward from MEM.
        do_reset();
        load_hazard(5, 5);
        tick();
        chk("lu_state1", 32'(hz.state_out), 1);
        chk("lu_bubble1", 32'(hz.bubble_count), 1);
        mem_rd_write = 1; mem_rd = 5; ex_branch_tkn = 1;
        #1;
        chk("lu_nostall", 32'(ctl(0)), 32'(9'b00000_01_00));
        tick();
        idle();
        #1;
        chk("lu_state_back", 32'(hz.state_out), 0);
        chk("lu_bubble_end", 32'(hz.bubble_count), 1);

        // Taken branch with a two-cycle flush, and the single-cycle variant.
        do_reset();
        ex_branch_tkn = 1;
        #1;
        chk("br_c1", 32'(ctl(0)), 32'(9'b00011_00_00));
        tick();
        ex_branch_tkn = 0;
        #1;
        chk("br_state2", 32'(hz.state_out), 2);
        chk("br_c2", 32'(ctl(0)), 32'(9'b00010_00_00));
        chk("br1_state", 32'(h1.state_out), 0);
        chk("br1_c2_flush", 32'(h1.flush_id), 0);
        tick();
        chk("br_state_back", 32'(hz.state_out), 0);
        chk("br_c3", 32'(ctl(0)), 0);
        chk("br_bubble", 32'(hz.bubble_count), 2);
        chk("br1_bubble", 32'(h1.bubble_count), 1);

        // Memory wait with a branch arriving in the first busy cycle.
        do_reset();
        mem_busy = 1; ex_branch_tkn = 1;
        #1;
        chk("mw_c1", 32'(ctl(0)), 32'(9'b11100_00_00));
        tick();
        ex_branch_tkn = 0;
        chk("mw_state", 32'(hz.state_out), 3);
        tick();
        chk("mw_c3", 32'(ctl(0)), 32'(9'b11100_00_00));
        tick();
        mem_busy = 0;
        #1;
        chk("mw_release", 32'(ctl(0)), 32'(9'b00011_00_00));
        tick();
        chk("mw_flush_state", 32'(hz.state_out), 2);
        chk("mw_flush_c2", 32'(ctl(0)), 32'(9'b00010_00_00));
        tick();
        tick();
        chk("mw_pend_clear", 32'(hz.state_out), 0);
        chk("mw_no_reflush", 32'(ctl(0)), 0);
        chk("mw_bubble", 32'(hz.bubble_count), 5);

        // Reset in the middle of a flush.
        do_reset();
        ex_branch_tkn = 1;
        tick();
        chk("rf_in_flush", 32'(hz.state_out), 2);
        rst_n = 0; mem_busy = 1;
        #1;
        chk("rf_forced0", 32'(ctl(0)), 0);
        tick();
        rst_n = 1;
        idle();
        #1;
        chk("rf_state", 32'(hz.state_out), 0);
        chk("rf_ctl", 32'(ctl(0)), 0);
        chk("rf_bubble", 32'(hz.bubble_count), 0);

        // Saturation of the narrow counter.
        do_reset();
        mem_busy = 1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", 32'(h4.bubble_count), 14);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_20", 32'(h4.bubble_count), 15);
        chk("wide_20", 32'(hz.bubble_count), 20);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
